// File: rtl/mem_backing_store_pkg.sv
// mem_pkg: definitions shared by the backing-store slice.
// Contents:
//   mem_state_e  - access FSM states (IDLE / BUSY / DONE)
//   DEFAULT_*    - default geometry and latency
//   WORD_SIZE    - width of one addressable word (32 bits)
//   init_word    - power-on content of one array word (its own word address)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int DEFAULT_ADDR_LENGTH = 10;
    localparam int DEFAULT_BLOCK_SIZE  = 64;
    localparam int DEFAULT_MEM_DELAY   = 20;
    localparam int WORD_SIZE           = 32;

    // Each 32-bit word of the array resets to its own word address.
    function automatic logic [WORD_SIZE-1:0] init_word(input int block_idx,
                                                       input int word_idx,
                                                       input int words_per_block);
        return WORD_SIZE'(block_idx * words_per_block + word_idx);
    endfunction

endpackage

// File: rtl/mem_backing_store_if.sv
// mem_backing_store_if: request/response bundle between the last-level cache
// (master) and the backing store (slave).
// Signals:
//   addrIn, dataUpIn, enableIn, writeIn       - request, driven by master
//   dataUpOut, fetchComplete, writeCompleteOut - response, driven by slave
//   readCount, writeCount                      - access statistics, present only
//                                                when MEM_STATS_EN is defined
interface mem_backing_store_if
    import mem_pkg::*;
#(
    parameter int ADDR_LENGTH = DEFAULT_ADDR_LENGTH,
    parameter int BLOCK_SIZE  = DEFAULT_BLOCK_SIZE
);

    logic [ADDR_LENGTH-1:0] addrIn;
    logic [BLOCK_SIZE-1:0]  dataUpIn;
    logic                   enableIn;
    logic                   writeIn;
    logic [BLOCK_SIZE-1:0]  dataUpOut;
    logic                   fetchComplete;
    logic                   writeCompleteOut;
`ifdef MEM_STATS_EN
    logic [15:0]            readCount;
    logic [15:0]            writeCount;
`endif

    modport master (
        output addrIn,
        output dataUpIn,
        output enableIn,
        output writeIn,
`ifdef MEM_STATS_EN
        input  readCount,
        input  writeCount,
`endif
        input  dataUpOut,
        input  fetchComplete,
        input  writeCompleteOut
    );

    modport slave (
        input  addrIn,
        input  dataUpIn,
        input  enableIn,
        input  writeIn,
`ifdef MEM_STATS_EN
        output readCount,
        output writeCount,
`endif
        output dataUpOut,
        output fetchComplete,
        output writeCompleteOut
    );

endinterface

// File: rtl/mem_backing_store_delay_timer.sv
// mem_delay_timer: 8-bit down-counter that paces one memory access.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, counter to 0
//   load   - load LOAD_VALUE
//   enable - decrement by one (stops at 0)
//   clear  - force counter to 0 (highest priority)
//   done   - counter is 0
module mem_delay_timer #(
    parameter logic [7:0] LOAD_VALUE = 8'd19
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    input  logic clear,
    output logic done
);

    logic [7:0] count_r;

    // Down-counter: clear beats load beats decrement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= LOAD_VALUE;
        end else if (enable && (count_r != 8'd0)) begin
            count_r <= count_r - 8'd1;
        end
    end

    assign done = (count_r == 8'd0);

endmodule

// File: rtl/mem_backing_store.sv
// mem_backing_store: fixed-latency block memory behind the last-level cache.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset (state, flags, read data, array init)
//   bus   - mem_backing_store_if.slave (request in, response/completion out)
// Parameters: ADDR_LENGTH (word address bits), BLOCK_SIZE (bits per transfer,
// multiple of 32), MEM_DELAY (1..255 cycles from accept to completion).
// Optional build macro MEM_STATS_EN adds saturating 16-bit read/write counters.
// A request is accepted in IDLE, latched, and completes MEM_DELAY cycles later;
// the completion flag is held until enableIn drops. Dropping enableIn while
// BUSY aborts the access without touching the array.
module mem_backing_store
    import mem_pkg::*;
#(
    parameter int ADDR_LENGTH = DEFAULT_ADDR_LENGTH,
    parameter int BLOCK_SIZE  = DEFAULT_BLOCK_SIZE,
    parameter int MEM_DELAY   = DEFAULT_MEM_DELAY
) (
    input  logic               clock,
    input  logic               reset,
    mem_backing_store_if.slave bus
);

    localparam int WORDS_PER_BLOCK = BLOCK_SIZE / WORD_SIZE;
    localparam int WSEL            = $clog2(WORDS_PER_BLOCK);
    localparam int BLK_BITS        = ADDR_LENGTH - WSEL;
    localparam int NUM_BLOCKS      = 1 << BLK_BITS;

    mem_state_e state_r;
    mem_state_e state_next_s;

    logic [BLOCK_SIZE-1:0] mem_r [NUM_BLOCKS];

    logic [BLK_BITS-1:0]   blk_lat_r;
    logic                  write_lat_r;
    logic [BLOCK_SIZE-1:0] data_lat_r;

    logic [BLOCK_SIZE-1:0] data_out_r;
    logic                  fetch_r;
    logic                  write_done_r;

    logic accept_s;
    logic timer_load_s;
    logic timer_enable_s;
    logic timer_clear_s;
    logic timer_done_s;
    logic rd_done_s;
    logic wr_done_s;
    logic flag_clear_s;

    mem_delay_timer #(
        .LOAD_VALUE (8'(MEM_DELAY - 1))
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load_s),
        .enable (timer_enable_s),
        .clear  (timer_clear_s),
        .done   (timer_done_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.enableIn) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (!bus.enableIn) begin
                    state_next_s = IDLE;
                end else if (timer_done_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (bus.enableIn) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode: timer control, access completion and flag release.
    always_comb begin
        accept_s       = 1'b0;
        timer_load_s   = 1'b0;
        timer_enable_s = 1'b0;
        timer_clear_s  = 1'b0;
        rd_done_s      = 1'b0;
        wr_done_s      = 1'b0;
        flag_clear_s   = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s     = bus.enableIn;
                timer_load_s = bus.enableIn;
            end
            BUSY: begin
                if (!bus.enableIn) begin
                    // Abort: discard the access, leave the counter at 0.
                    timer_clear_s = 1'b1;
                end else if (timer_done_s) begin
                    rd_done_s = !write_lat_r;
                    wr_done_s = write_lat_r;
                end else begin
                    timer_enable_s = 1'b1;
                end
            end
            DONE: begin
                flag_clear_s = !bus.enableIn;
            end
            default: begin
                flag_clear_s = 1'b1;
            end
        endcase
    end

    // Request latch: captured once at acceptance, inputs ignored afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blk_lat_r   <= {BLK_BITS{1'b0}};
            write_lat_r <= 1'b0;
            data_lat_r  <= {BLOCK_SIZE{1'b0}};
        end else if (accept_s) begin
            blk_lat_r   <= bus.addrIn[ADDR_LENGTH-1:WSEL];
            write_lat_r <= bus.writeIn;
            data_lat_r  <= bus.dataUpIn;
        end
    end

    // Storage array: reset fills each word with its word address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                    mem_r[b][w*WORD_SIZE +: WORD_SIZE] <= init_word(b, w, WORDS_PER_BLOCK);
                end
            end
        end else if (wr_done_s) begin
            mem_r[blk_lat_r] <= data_lat_r;
        end
    end

    // Read data register: only a completed read updates it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out_r <= {BLOCK_SIZE{1'b0}};
        end else if (rd_done_s) begin
            data_out_r <= mem_r[blk_lat_r];
        end
    end

    // Completion flags: set on completion, held through DONE, mutually exclusive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_r      <= 1'b0;
            write_done_r <= 1'b0;
        end else if (rd_done_s) begin
            fetch_r      <= 1'b1;
            write_done_r <= 1'b0;
        end else if (wr_done_s) begin
            fetch_r      <= 1'b0;
            write_done_r <= 1'b1;
        end else if (flag_clear_s) begin
            fetch_r      <= 1'b0;
            write_done_r <= 1'b0;
        end
    end

    assign bus.dataUpOut        = data_out_r;
    assign bus.fetchComplete    = fetch_r;
    assign bus.writeCompleteOut = write_done_r;

`ifdef MEM_STATS_EN
    logic [15:0] read_count_r;
    logic [15:0] write_count_r;

    // Saturating access counters; aborted requests never reach completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_count_r  <= 16'd0;
            write_count_r <= 16'd0;
        end else begin
            if (rd_done_s && (read_count_r != 16'hFFFF)) begin
                read_count_r <= read_count_r + 16'd1;
            end
            if (wr_done_s && (write_count_r != 16'hFFFF)) begin
                write_count_r <= write_count_r + 16'd1;
            end
        end
    end

    assign bus.readCount  = read_count_r;
    assign bus.writeCount = write_count_r;
`endif

endmodule

// File: tb/tb_mem_backing_store.sv
// Bench for mem_backing_store (MEM_DELAY=20, BLOCK_SIZE=64, ADDR_LENGTH=10).
// Directed vector table, hand-written corner sequences, then random requests
// checked against a word-addressed reference array.
`timescale 1ns/1ps
module tb_mem_backing_store;
    import mem_pkg::*;

    localparam int AL     = 10;
    localparam int BS     = 64;
    localparam int MD     = 20;
    localparam int NWORDS = 1 << AL;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [NWORDS];
    logic [63:0] last_rd;
    int          exp_rd_cnt;
    int          exp_wr_cnt;

    mem_backing_store_if #(.ADDR_LENGTH(AL), .BLOCK_SIZE(BS)) bus();

    mem_backing_store #(
        .ADDR_LENGTH (AL),
        .BLOCK_SIZE  (BS),
        .MEM_DELAY   (MD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        bit          wr;
        int          addr;
        logic [63:0] data;
        int          abort_at;
        int          hold;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'(i);
        last_rd    = 64'd0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
    endtask

    // A 64-bit block is two consecutive words; the odd word is the upper half.
    function automatic logic [63:0] model_read(input int addr);
        int b = addr / 2;
        return {ref_mem[2*b+1], ref_mem[2*b]};
    endfunction

    task automatic model_write(input int addr, input logic [63:0] data);
        int b = addr / 2;
        ref_mem[2*b]   = data[31:0];
        ref_mem[2*b+1] = data[63:32];
    endtask

    // One full request; use_tab selects the table's expected read value.
    task automatic run_req(input string name, input bit wr, input int addr,
                           input logic [63:0] data, input int abort_at, input int hold,
                           input bit use_tab, input logic [63:0] tab_exp);
        int k;
        logic [63:0] exp;
        exp = use_tab ? tab_exp : model_read(addr);
        @(negedge clock);
        bus.enableIn = 1'b1;
        bus.writeIn  = wr;
        bus.addrIn   = AL'(addr);
        bus.dataUpIn = data;
        @(posedge clock);
        @(negedge clock);
        // Scramble inputs: the latched request must be used.
        bus.writeIn  = ~wr;
        bus.addrIn   = AL'($urandom);
        bus.dataUpIn = {$urandom, $urandom};
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clock);
            bus.enableIn = 1'b0;
            k = 0;
            repeat (2*MD) begin
                @(negedge clock);
                if (bus.fetchComplete || bus.writeCompleteOut) k++;
            end
            check({name, " abort no flag"}, 64'(k), 64'd0);
            check({name, " abort dataUpOut held"}, bus.dataUpOut, last_rd);
        end else begin
            k = 0;
            while (!(bus.fetchComplete || bus.writeCompleteOut) && k < 4*MD) begin
                @(posedge clock);
                k++;
                @(negedge clock);
            end
            check({name, " latency"}, 64'(k), 64'(MD));
            check({name, " flags"}, {62'd0, bus.fetchComplete, bus.writeCompleteOut},
                  wr ? 64'd1 : 64'd2);
            if (wr) begin
                model_write(addr, data);
                exp_wr_cnt++;
                check({name, " dataUpOut unchanged by write"}, bus.dataUpOut, last_rd);
            end else begin
                check({name, " read data"}, bus.dataUpOut, exp);
                last_rd = exp;
                exp_rd_cnt++;
            end
            if (hold > 0) begin
                bus.addrIn   = 10'd12;
                bus.writeIn  = 1'b1;
                bus.dataUpIn = 64'hFFFF_FFFF_FFFF_FFFF;
                k = 0;
                repeat (hold) begin
                    @(negedge clock);
                    if (bus.fetchComplete !== 1'b1 || bus.writeCompleteOut !== 1'b0 ||
                        bus.dataUpOut !== exp) k++;
                end
                check({name, " hold stable cycles bad"}, 64'(k), 64'd0);
            end
            bus.enableIn = 1'b0;
            @(negedge clock);
            check({name, " flags cleared"}, {62'd0, bus.fetchComplete, bus.writeCompleteOut}, 64'd0);
        end
    endtask

    initial begin
        bus.enableIn = 1'b0;
        bus.writeIn  = 1'b0;
        bus.addrIn   = '0;
        bus.dataUpIn = '0;
        model_init();

        vecs[0] = '{"rd0",      1'b0, 0,    64'd0,                   0, 0,  64'h00000001_00000000};
        vecs[1] = '{"wr4",      1'b1, 4,    64'hDEADBEEF_CAFEF00D,   0, 0,  64'd0};
        vecs[2] = '{"rd5",      1'b0, 5,    64'd0,                   0, 0,  64'hDEADBEEF_CAFEF00D};
        vecs[3] = '{"wr8abort", 1'b1, 8,    64'h1,                   5, 0,  64'd0};
        vecs[4] = '{"rd8",      1'b0, 8,    64'd0,                   0, 0,  64'h00000009_00000008};
        vecs[5] = '{"hold",     1'b0, 2,    64'd0,                   0, 50, 64'h00000003_00000002};
        vecs[6] = '{"rd12",     1'b0, 12,   64'd0,                   0, 0,  64'h0000000D_0000000C};
        vecs[7] = '{"rd1023",   1'b0, 1023, 64'd0,                   0, 0,  64'h000003FF_000003FE};
        vecs[8] = '{"wr1022",   1'b1, 1022, 64'h01234567_89ABCDEF,   0, 0,  64'd0};
        vecs[9] = '{"rd1023b",  1'b0, 1023, 64'd0,                   0, 0,  64'h01234567_89ABCDEF};

        // Reset state while reset is held.
        #12;
        check("reset fetchComplete", {63'd0, bus.fetchComplete}, 64'd0);
        check("reset writeCompleteOut", {63'd0, bus.writeCompleteOut}, 64'd0);
        check("reset dataUpOut", bus.dataUpOut, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[i])
            run_req(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].data,
                    vecs[i].abort_at, vecs[i].hold, 1'b1, vecs[i].exp_rd);

`ifdef MEM_STATS_EN
        check("readCount", {48'd0, bus.readCount}, 64'(exp_rd_cnt));
        check("writeCount", {48'd0, bus.writeCount}, 64'(exp_wr_cnt));
`endif

        // Reset in the middle of a read: outputs clear at once, array reinitialised.
        @(negedge clock);
        bus.enableIn = 1'b1;
        bus.writeIn  = 1'b0;
        bus.addrIn   = 10'd6;
        @(posedge clock);
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midbusy reset fetchComplete", {63'd0, bus.fetchComplete}, 64'd0);
        check("midbusy reset writeCompleteOut", {63'd0, bus.writeCompleteOut}, 64'd0);
        check("midbusy reset dataUpOut", bus.dataUpOut, 64'd0);
`ifdef MEM_STATS_EN
        check("midbusy reset readCount", {48'd0, bus.readCount}, 64'd0);
`endif
        bus.enableIn = 1'b0;
        model_init();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_req("rd4 after reset", 1'b0, 4, 64'd0, 0, 0, 1'b1, 64'h00000005_00000004);
        run_req("rd1022 after reset", 1'b0, 1022, 64'd0, 0, 0, 1'b1, 64'h000003FF_000003FE);

        // Random requests against the reference array.
        for (int n = 0; n < 30; n++) begin
            bit          wr;
            int          addr;
            int          ab;
            logic [63:0] d;
            wr   = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, NWORDS - 1));
            d    = {$urandom, $urandom};
            ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 18)) : 0;
            run_req($sformatf("rand%0d", n), wr, addr, d, ab, 0, 1'b0, 64'd0);
        end

`ifdef MEM_STATS_EN
        check("final readCount", {48'd0, bus.readCount}, 64'(exp_rd_cnt));
        check("final writeCount", {48'd0, bus.writeCount}, 64'(exp_wr_cnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_backing_store.md
MEM_BACKING_STORE -- requirements
Module: mem_backing_store

Interface
REQ-001 Parameter ADDR_LENGTH, default 10: word-address width, matching the cache down-side addrOut.
REQ-002 Parameter BLOCK_SIZE, default 64: data width in bits of one transfer, a multiple of 32.
REQ-003 Parameter MEM_DELAY, default 20: access latency in cycles, legal range 1..255.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 addrIn  input  ADDR_LENGTH  word address from the last-level cache.
REQ-007 dataUpIn  input  BLOCK_SIZE  block write data.
REQ-008 enableIn  input  1  level request, held high until completion.
REQ-009 writeIn  input  1  1 = write request, 0 = read request.
REQ-010 dataUpOut  output  BLOCK_SIZE  block read data.
REQ-011 fetchComplete  output  1  read done.
REQ-012 writeCompleteOut  output  1  write done.

Function
REQ-013 Storage: 2^ADDR_LENGTH/(BLOCK_SIZE/32) blocks; block index = addrIn[ADDR_LENGTH-1:WSEL], WSEL = log2(BLOCK_SIZE/32); word-select bits are ignored.
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE: enableIn=1 sampled -> latch addrIn, writeIn, dataUpIn; load delay counter with MEM_DELAY-1; go to BUSY.
REQ-016 BUSY: counter decrements each cycle; at 0 -> DONE; total latency from accepting edge to complete-visible = MEM_DELAY cycles.
REQ-017 BUSY->DONE, read: dataUpOut <= stored block, fetchComplete <= 1.
REQ-018 BUSY->DONE, write: block <= latched data, writeCompleteOut <= 1.
REQ-019 The completion flag is registered and held throughout DONE; only one of fetchComplete and writeCompleteOut is ever high.
REQ-020 DONE: enableIn=0 -> both flags cleared, IDLE next cycle; enableIn=1 -> stay in DONE, input changes ignored.
REQ-021 A new request requires at least one cycle with enableIn=0 after DONE; back-to-back requests without that low cycle are not accepted.
REQ-022 Abort: enableIn=0 during BUSY -> IDLE next edge, no completion, no array write.
REQ-023 dataUpOut holds the last read block until the next read completes; it is unchanged by writes.
REQ-024 Inputs are ignored in BUSY except enableIn; latched values are used for the access.

Reset
REQ-025 reset low forces immediately: state IDLE, counter 0, fetchComplete 0, writeCompleteOut 0, dataUpOut 0.
REQ-026 reset low initialises every 32-bit word of the array to its own word address (block b, word w = b*(BLOCK_SIZE/32)+w).
REQ-027 Reset asserted mid-BUSY discards the request; no array write occurs.

Configuration
REQ-028 With macro MEM_STATS_EN defined, add outputs readCount and writeCount, each 16 bits, reset to 0, incremented on each completed read or write, saturating at 16'hFFFF; aborted requests are not counted.
REQ-029 Without MEM_STATS_EN, these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-030 Shared package mem_pkg holds: the state enum (IDLE/BUSY/DONE), default constants for ADDR_LENGTH/BLOCK_SIZE/MEM_DELAY, and the word-size constant 32.
REQ-031 Sub-module mem_delay_timer: load, enable and clear inputs; a done output; 8-bit down-counter.
REQ-032 The array is a flat register array inside mem_backing_store.

Verification (MEM_DELAY=20, BLOCK_SIZE=64)
REQ-033 Reset: release reset, then read addr 0 -> fetchComplete=1 exactly 20 cycles after acceptance, with dataUpOut=64'h00000001_00000000.
REQ-034 Write/read-back: write addr 4 with 64'hDEADBEEF_CAFEF00D -> writeCompleteOut after 20 cycles; then read addr 5 -> dataUpOut=64'hDEADBEEF_CAFEF00D.
REQ-035 Abort: write addr 8 with 64'h1 and drop enableIn at cycle 5 -> no completion flag; a following read of addr 8 returns 64'h00000009_00000008.
REQ-036 Hold: after DONE, keep enableIn high for 50 cycles while changing addrIn to 12 -> fetchComplete stays 1, dataUpOut unchanged, no second access.
REQ-037 Reset mid-BUSY: assert reset at cycle 10 of a read -> all outputs 0 immediately, state IDLE, array reinitialised.
REQ-038 MEM_STATS_EN: run 3 reads, 2 writes and 1 aborted read -> readCount=3, writeCount=2.
